// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measured-signal input and result bundle for clk_period_meter
//
// Purpose: carries the measured signal into the meter and its results back out.
// Signals:
//   sigIn      measured signal, asynchronous to the meter clock
//   periodOut  last measured period, in meter clock cycles
//   highOut    meter clock cycles sigIn was high within that period
//   validOut   one-cycle pulse when periodOut/highOut update
//   riseOut    one-cycle pulse per detected rising edge of sigIn
//   stuckOut   level, no rising edge seen for the timeout interval
// Modports:
//   master  the meter (drives results, receives sigIn)
//   slave   the user of the results (drives sigIn, receives results)
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sigIn;
  logic [CNT_W-1:0] periodOut;
  logic [CNT_W-1:0] highOut;
  logic             validOut;
  logic             riseOut;
  logic             stuckOut;

  modport master (
    input  sigIn,
    output periodOut,
    output highOut,
    output validOut,
    output riseOut,
    output stuckOut
  );

  modport slave (
    output sigIn,
    input  periodOut,
    input  highOut,
    input  validOut,
    input  riseOut,
    input  stuckOut
  );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period, high-time and stuck detection for a slow input clock
//
// Purpose: synchronises sigIn into the inClk domain, measures the distance
// between successive rising edges and the number of high cycles in between,
// and flags an input that stops toggling.
// Ports:
//   inClk    system clock, all logic on its rising edge
//   inRst_n  asynchronous active-low reset
//   mif      clk_period_meter_if master modport (sigIn in; periodOut,
//            highOut, validOut, riseOut, stuckOut out)
// Parameters:
//   CNT_W        counter and result width
//   SYNC_STAGES  synchroniser depth, at least 2
//   TIMEOUT      cycles without a rising edge before stuck, < 2**CNT_W
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                 inClk,
  input  logic                 inRst_n,
  clk_period_meter_if.master   mif
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   p_q, p_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   stuck_q, stuck_d;

  logic s;
  logic rise;

  // Oldest synchroniser stage is the only one the rest of the design sees.
  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], mif.sigIn};
    p_d        = s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cnt_d = high_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;

    unique case (state_q)
      IDLE: begin
        // First edge only arms the meter; the partial period before it is
        // never reported.
        cnt_d      = '0;
        high_cnt_d = '0;
        if (rise) begin
          state_d    = MEASURE;
          cnt_d      = ONE_C;
          high_cnt_d = ONE_C;
          stuck_d    = 1'b0;
        end
      end

      MEASURE: begin
        if (rise) begin
          // A rise on the timeout cycle still counts as a normal capture.
          period_d   = cnt_q;
          high_d     = high_cnt_q;
          valid_d    = 1'b1;
          cnt_d      = ONE_C;
          high_cnt_d = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d    = IDLE;
          stuck_d    = 1'b1;
          cnt_d      = '0;
          high_cnt_d = '0;
        end else begin
          cnt_d      = cnt_q + ONE_C;
          high_cnt_d = high_cnt_q + CNT_W'(s);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      sync_q     <= '0;
      p_q        <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      p_q        <= p_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cnt_q <= high_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
    end
  end

  assign mif.periodOut = period_q;
  assign mif.highOut   = high_q;
  assign mif.validOut  = valid_q;
  assign mif.riseOut   = rise;
  assign mif.stuckOut  = stuck_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - scoreboard bench for clk_period_meter
module tb_clk_period_meter;

  localparam int TIMEOUT_A = 20;
  localparam int TIMEOUT_B = 10;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
  } exp_t;

  logic inClk = 1'b0;
  logic rst_n;
  logic rst_b_n;

  always #5 inClk = ~inClk;

  clk_period_meter_if #(.CNT_W(16)) if_a ();
  clk_period_meter_if #(.CNT_W(16)) if_b ();

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT_A)) u_dut_a (
    .inClk   (inClk),
    .inRst_n (rst_n),
    .mif     (if_a)
  );

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT_B)) u_dut_b (
    .inClk   (inClk),
    .inRst_n (rst_b_n),
    .mif     (if_b)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  int   rises_driven = 0;
  int   rises_seen = 0;
  int   last_rise = 0;
  logic stuck_prev = 1'b0;
  logic clear_pend = 1'b0;
  logic stuck_b_seen = 1'b0;
  logic b_done = 1'b0;

  int   prev_per = 0;
  int   prev_hi = 0;
  logic have_prev = 1'b0;

  always @(posedge inClk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge inClk);
    #1;
  endtask

  // One period of sigIn starting with a rise; the period before it becomes
  // an expected result once the meter is armed.
  task automatic drive_period(input int per, input int hi);
    rises_driven++;
    if (have_prev) q_a.push_back('{per: 16'(prev_per), hi: 16'(prev_hi)});
    prev_per  = per;
    prev_hi   = hi;
    have_prev = 1'b1;
    if_a.sigIn = 1'b1;
    hold(hi);
    if_a.sigIn = 1'b0;
    hold(per - hi);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    hold(2);
    rst_n = 1'b1;
    have_prev = 1'b0;
  endtask

  // Monitor for the TIMEOUT=20 instance.
  always @(negedge inClk) begin
    if (!rst_n) begin
      stuck_prev = 1'b0;
      clear_pend = 1'b0;
    end else begin
      if (clear_pend) begin
        check("stuck_clear_after_rise", int'(if_a.stuckOut), 0);
        clear_pend = 1'b0;
      end
      if (if_a.riseOut) begin
        rises_seen++;
        last_rise = cyc;
        if (if_a.stuckOut) clear_pend = 1'b1;
      end
      if (if_a.stuckOut && !stuck_prev)
        check("stuck_delay_from_rise", cyc - last_rise, TIMEOUT_A + 1);
      stuck_prev = if_a.stuckOut;
      if (if_a.validOut) begin
        if (q_a.size() == 0) begin
          check("unexpected_valid_a", 1, 0);
        end else begin
          e_a = q_a.pop_front();
          check("period_a", int'(if_a.periodOut), int'(e_a.per));
          check("high_a", int'(if_a.highOut), int'(e_a.hi));
        end
      end
    end
  end

  // Monitor for the TIMEOUT=10 instance.
  always @(negedge inClk) begin
    if (rst_b_n) begin
      if (if_b.stuckOut) stuck_b_seen = 1'b1;
      if (if_b.validOut) begin
        if (q_b.size() == 0) begin
          check("unexpected_valid_b", 1, 0);
        end else begin
          e_b = q_b.pop_front();
          check("period_b", int'(if_b.periodOut), int'(e_b.per));
          check("high_b", int'(if_b.highOut), int'(e_b.hi));
        end
      end
    end
  end

  // Period equal to TIMEOUT: every rise lands on cnt==TIMEOUT.
  initial begin
    rst_b_n    = 1'b0;
    if_b.sigIn = 1'b0;
    hold(3);
    rst_b_n = 1'b1;
    hold(3);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) q_b.push_back('{per: 16'd10, hi: 16'd5});
      if_b.sigIn = 1'b1;
      hold(5);
      if_b.sigIn = 1'b0;
      hold(5);
    end
    rst_b_n = 1'b0;
    b_done  = 1'b1;
  end

  initial begin
    rst_n      = 1'b0;
    if_a.sigIn = 1'b0;
    hold(3);
    check("rst_period", int'(if_a.periodOut), 0);
    check("rst_high", int'(if_a.highOut), 0);
    check("rst_valid", int'(if_a.validOut), 0);
    check("rst_rise", int'(if_a.riseOut), 0);
    check("rst_stuck", int'(if_a.stuckOut), 0);
    rst_n = 1'b1;
    hold(3);

    // 50% duty, divide by 10
    repeat (6) drive_period(10, 5);
    check("t1_stuck", int'(if_a.stuckOut), 0);

    // period 7 high 2, then period 3 high 1
    repeat (4) drive_period(7, 2);
    repeat (4) drive_period(3, 1);

    // stop toggling: stuck, results retained, then restart
    repeat (4) drive_period(10, 5);
    hold(40);
    have_prev = 1'b0;
    check("t3_stuck", int'(if_a.stuckOut), 1);
    check("t3_period_kept", int'(if_a.periodOut), 10);
    check("t3_high_kept", int'(if_a.highOut), 5);
    repeat (3) drive_period(10, 5);

    // never armed: no stuck; then a single rise and constant high
    reset_pulse();
    hold(40);
    check("t4_idle_no_stuck", int'(if_a.stuckOut), 0);
    if_a.sigIn = 1'b1;
    rises_driven++;
    hold(40);
    have_prev = 1'b0;
    check("t4_const_high_stuck", int'(if_a.stuckOut), 1);
    if_a.sigIn = 1'b0;
    hold(5);

    // asynchronous reset in the middle of a period
    repeat (4) drive_period(10, 5);
    hold(2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_period", int'(if_a.periodOut), 0);
    check("async_rst_high", int'(if_a.highOut), 0);
    check("async_rst_valid", int'(if_a.validOut), 0);
    check("async_rst_rise", int'(if_a.riseOut), 0);
    check("async_rst_stuck", int'(if_a.stuckOut), 0);
    hold(2);
    rst_n = 1'b1;
    have_prev = 1'b0;
    hold(3);
    repeat (4) drive_period(10, 5);
    hold(40);

    check("a_queue_drained", q_a.size(), 0);
    check("rise_count", rises_seen, rises_driven);
    check("b_done", int'(b_done), 1);
    check("b_queue_drained", q_b.size(), 0);
    check("b_never_stuck", int'(stuck_b_seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
